// File: rtl/sound_latch_if.sv
// Command-latch bus: main-CPU write/status strobes, sound-CPU read/ack strobes, and latch status.
interface sound_latch_if;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned LVL_W  = 3;

  logic              snd_wr;
  logic [DATA_W-1:0] main_din;
  logic              stat_rd;
  logic              snd_rd;
  logic              snd_ack;
  logic [DATA_W-1:0] snd_dout;
  logic              snd_irq_n;
  logic              pending;
  logic              overrun;
  logic [LVL_W-1:0]  level;
  logic              rd_seen;

  // Strobe driver side (main CPU decode plus sound CPU strobes)
  modport master (
    output snd_wr, main_din, stat_rd, snd_rd, snd_ack,
    input  snd_dout, snd_irq_n, pending, overrun, level, rd_seen
  );

  // Latch side
  modport slave (
    input  snd_wr, main_din, stat_rd, snd_rd, snd_ack,
    output snd_dout, snd_irq_n, pending, overrun, level, rd_seen
  );
endinterface

// File: rtl/sound_latch.sv
// Sound command latch: captures main-CPU command bytes, interrupts the sound CPU
// and holds the byte until acknowledged.
// Build option: define SOUND_LATCH_FIFO_EN for a 4-deep command FIFO; otherwise
// a single overwrite latch is built.
module sound_latch (
  input  logic         clk,
  input  logic         reset_n,
  sound_latch_if.slave bus
);
  localparam int unsigned DATA_W = 8;
  localparam int unsigned LVL_W  = 3;

  logic wr_prev_q, rd_prev_q, ack_prev_q, stat_prev_q;
  logic wr_ev_c, rd_ev_c, ack_ev_c, stat_ev_c;

  logic [DATA_W-1:0] dout_q, dout_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              pending_q, pending_d;
  logic              irq_n_q, irq_n_d;
  logic              overrun_q, overrun_d;
  logic              rd_seen_q, rd_seen_d;
  logic              overrun_set_c;

  // Strobe history; reset high so a strobe held across reset release is not an event
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_prev_q   <= 1'b1;
      rd_prev_q   <= 1'b1;
      ack_prev_q  <= 1'b1;
      stat_prev_q <= 1'b1;
    end else begin
      wr_prev_q   <= bus.snd_wr;
      rd_prev_q   <= bus.snd_rd;
      ack_prev_q  <= bus.snd_ack;
      stat_prev_q <= bus.stat_rd;
    end
  end

  // Rising-edge events
  always_comb begin
    wr_ev_c   = bus.snd_wr  & ~wr_prev_q;
    rd_ev_c   = bus.snd_rd  & ~rd_prev_q;
    ack_ev_c  = bus.snd_ack & ~ack_prev_q;
    stat_ev_c = bus.stat_rd & ~stat_prev_q;
  end

`ifdef SOUND_LATCH_FIFO_EN
  localparam int unsigned DEPTH = 4;
  localparam int unsigned PTR_W = 2;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic              pop_c, push_c, full_c, empty_c;

  // FIFO control: ack pops when not empty; a write on a full FIFO only lands if a pop frees a slot
  always_comb begin
    empty_c       = (level_q == '0);
    full_c        = (level_q == LVL_W'(DEPTH));
    pop_c         = ack_ev_c & ~empty_c;
    push_c        = wr_ev_c & (~full_c | pop_c);
    overrun_set_c = wr_ev_c & full_c & ~pop_c;
    rd_ptr_d      = pop_c  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    wr_ptr_d      = push_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    level_d       = level_q;
    if (push_c && !pop_c) begin
      level_d = level_q + LVL_W'(1);
    end else if (pop_c && !push_c) begin
      level_d = level_q - LVL_W'(1);
    end
    // Head after update; the byte being pushed is the head if it lands at the new read slot
    if (level_d == '0) begin
      dout_d = dout_q;
    end else if (push_c && (rd_ptr_d == wr_ptr_q)) begin
      dout_d = bus.main_din;
    end else begin
      dout_d = mem_q[rd_ptr_d];
    end
  end

  // FIFO storage and pointers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      if (push_c) begin
        mem_q[wr_ptr_q] <= bus.main_din;
      end
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end
`else
  logic held_d;

  // Single latch: write overwrites; ack retires; write+ack retires old and holds new
  always_comb begin
    overrun_set_c = wr_ev_c & pending_q & ~ack_ev_c;
    held_d        = pending_q;
    if (ack_ev_c) begin
      held_d = 1'b0;
    end
    if (wr_ev_c) begin
      held_d = 1'b1;
    end
    dout_d  = wr_ev_c ? bus.main_din : dout_q;
    level_d = {2'b00, held_d};
  end
`endif

  // Status derived from the next entry count; overrun set beats status-read clear
  always_comb begin
    pending_d = (level_d != '0);
    irq_n_d   = ~pending_d;
    overrun_d = overrun_q;
    if (stat_ev_c) begin
      overrun_d = 1'b0;
    end
    if (overrun_set_c) begin
      overrun_d = 1'b1;
    end
    rd_seen_d = rd_seen_q;
    if (ack_ev_c) begin
      rd_seen_d = 1'b0;
    end else if (rd_ev_c && pending_q) begin
      rd_seen_d = 1'b1;
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dout_q    <= '0;
      level_q   <= '0;
      pending_q <= 1'b0;
      irq_n_q   <= 1'b1;
      overrun_q <= 1'b0;
      rd_seen_q <= 1'b0;
    end else begin
      dout_q    <= dout_d;
      level_q   <= level_d;
      pending_q <= pending_d;
      irq_n_q   <= irq_n_d;
      overrun_q <= overrun_d;
      rd_seen_q <= rd_seen_d;
    end
  end

  assign bus.snd_dout  = dout_q;
  assign bus.level     = level_q;
  assign bus.pending   = pending_q;
  assign bus.snd_irq_n = irq_n_q;
  assign bus.overrun   = overrun_q;
  assign bus.rd_seen   = rd_seen_q;
endmodule

// File: tb/tb_sound_latch.sv
// Self-checking bench for sound_latch; FIFO scenarios run when SOUND_LATCH_FIFO_EN is defined.
module tb_sound_latch;
`ifdef SOUND_LATCH_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  logic clk;
  logic reset_n;
  sound_latch_if sif ();

  sound_latch dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cmp_cnt = 0;
  int err_cnt = 0;

  // Scoreboard: held bytes in order, last popped byte, sticky flags
  logic [7:0] model_q[$];
  logic [7:0] m_last;
  logic       m_ovr;
  logic       m_rds;

  task automatic model_reset();
    model_q.delete();
    m_last = 8'h00;
    m_ovr  = 1'b0;
    m_rds  = 1'b0;
  endtask

  task automatic model_step(input bit wr, input bit ack, input bit rd, input bit stat,
                            input logic [7:0] din);
    int sz0;
    sz0 = model_q.size();
    if (ack && sz0 > 0) m_last = model_q.pop_front();
    if (stat) m_ovr = 1'b0;
    if (wr) begin
      if (model_q.size() < CAP) begin
        model_q.push_back(din);
      end else begin
        m_ovr = 1'b1;
        if (CAP == 1) model_q[0] = din;
      end
    end
    if (ack) m_rds = 1'b0;
    else if (rd && sz0 > 0) m_rds = 1'b1;
  endtask

  // {dout, irq_n, pending, overrun, level, rd_seen}
  function automatic logic [14:0] obs();
    return {sif.snd_dout, sif.snd_irq_n, sif.pending, sif.overrun, sif.level, sif.rd_seen};
  endfunction

  function automatic logic [14:0] expv();
    int sz;
    logic [7:0] d;
    sz = model_q.size();
    d = (sz > 0) ? model_q[0] : m_last;
    return {d, (sz == 0), (sz > 0), m_ovr, 3'(sz), m_rds};
  endfunction

  // One strobe cycle high, then low; outputs for that event are visible on return
  task automatic pulse(input bit wr, input bit ack, input bit rd, input bit stat,
                       input logic [7:0] din);
    @(negedge clk);
    sif.snd_wr   = wr;
    sif.snd_ack  = ack;
    sif.snd_rd   = rd;
    sif.stat_rd  = stat;
    sif.main_din = din;
    model_step(wr, ack, rd, stat, din);
    @(negedge clk);
    sif.snd_wr  = 1'b0;
    sif.snd_ack = 1'b0;
    sif.snd_rd  = 1'b0;
    sif.stat_rd = 1'b0;
  endtask

  task automatic drain();
    while (model_q.size() > 0) pulse(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_reset();
    logic [14:0] rst_v;
    rst_v = {8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0};
    reset_n = 1'b0;
    sif.snd_wr = 1'b1;
    sif.snd_ack = 1'b0;
    sif.snd_rd = 1'b0;
    sif.stat_rd = 1'b0;
    sif.main_din = 8'hEE;
    model_reset();
    repeat (3) @(negedge clk);
    cmp_cnt++;
    if (obs() !== rst_v) begin
      err_cnt++;
      $display("FAIL reset_values: got %h required %h", obs(), rst_v);
    end
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    cmp_cnt++;
    if (obs() !== rst_v) begin
      err_cnt++;
      $display("FAIL wr_held_over_reset: got %h required %h", obs(), rst_v);
    end
    sif.snd_wr = 1'b0;
    @(negedge clk);
    cmp_cnt++;
    if (sif.pending !== 1'b0 || sif.snd_irq_n !== 1'b1) begin
      err_cnt++;
      $display("FAIL wr_fall_no_event: got pending=%b irq_n=%b required 0/1", sif.pending, sif.snd_irq_n);
    end
  endtask

  task automatic test_basic();
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 8'h5A);
    cmp_cnt++;
    if (sif.snd_irq_n !== 1'b0 || sif.snd_dout !== 8'h5A) begin
      err_cnt++;
      $display("FAIL write_5a: got irq_n=%b dout=%h required 0/5a", sif.snd_irq_n, sif.snd_dout);
    end
    pulse(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    cmp_cnt++;
    if (sif.rd_seen !== 1'b1 || obs() !== expv()) begin
      err_cnt++;
      $display("FAIL rd_seen_set: got %h required %h", obs(), expv());
    end
    pulse(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    cmp_cnt++;
    if (sif.snd_irq_n !== 1'b1 || sif.rd_seen !== 1'b0 || sif.snd_dout !== 8'h5A) begin
      err_cnt++;
      $display("FAIL ack_release: got irq_n=%b rd_seen=%b dout=%h required 1/0/5a",
               sif.snd_irq_n, sif.rd_seen, sif.snd_dout);
    end
    pulse(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    cmp_cnt++;
    if (obs() !== expv()) begin
      err_cnt++;
      $display("FAIL ack_when_empty: got %h required %h", obs(), expv());
    end
  endtask

  task automatic test_overwrite();
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 8'h11);
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 8'h22);
    cmp_cnt++;
    if (obs() !== expv()) begin
      err_cnt++;
      $display("FAIL second_write: got %h required %h", obs(), expv());
    end
`ifndef SOUND_LATCH_FIFO_EN
    cmp_cnt++;
    if (sif.snd_dout !== 8'h22 || sif.overrun !== 1'b1) begin
      err_cnt++;
      $display("FAIL overwrite: got dout=%h overrun=%b required 22/1", sif.snd_dout, sif.overrun);
    end
`endif
    pulse(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    cmp_cnt++;
    if (sif.overrun !== 1'b0 || obs() !== expv()) begin
      err_cnt++;
      $display("FAIL stat_clear: got %h required %h", obs(), expv());
    end
    drain();
  endtask

  task automatic test_wr_ack_same();
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 8'h11);
    pulse(1'b1, 1'b1, 1'b0, 1'b0, 8'h33);
    cmp_cnt++;
    if (sif.snd_dout !== 8'h33 || sif.pending !== 1'b1 || sif.overrun !== 1'b0) begin
      err_cnt++;
      $display("FAIL wr_ack_same: got dout=%h pending=%b overrun=%b required 33/1/0",
               sif.snd_dout, sif.pending, sif.overrun);
    end
    drain();
    cmp_cnt++;
    if (obs() !== expv()) begin
      err_cnt++;
      $display("FAIL drain_after_same: got %h required %h", obs(), expv());
    end
  endtask

`ifdef SOUND_LATCH_FIFO_EN
  task automatic test_fifo_fill();
    logic [7:0] exp_b;
    for (int i = 1; i <= 5; i++) pulse(1'b1, 1'b0, 1'b0, 1'b0, 8'(i));
    cmp_cnt++;
    if (sif.level !== 3'd4 || sif.overrun !== 1'b1 || sif.snd_dout !== 8'h01) begin
      err_cnt++;
      $display("FAIL fifo_full: got level=%0d overrun=%b dout=%h required 4/1/01",
               sif.level, sif.overrun, sif.snd_dout);
    end
    for (int i = 1; i <= 4; i++) begin
      exp_b = 8'(i);
      cmp_cnt++;
      if (sif.snd_dout !== exp_b) begin
        err_cnt++;
        $display("FAIL fifo_head_%0d: got %h required %h", i, sif.snd_dout, exp_b);
      end
      pulse(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    end
    cmp_cnt++;
    if (sif.snd_irq_n !== 1'b1 || sif.level !== 3'd0 || sif.snd_dout !== 8'h04) begin
      err_cnt++;
      $display("FAIL fifo_empty: got irq_n=%b level=%0d dout=%h required 1/0/04",
               sif.snd_irq_n, sif.level, sif.snd_dout);
    end
  endtask

  task automatic test_fifo_full_wr_ack();
    for (int i = 0; i < 5; i++) pulse(1'b1, 1'b0, 1'b0, 1'b0, 8'hA0 + 8'(i));
    pulse(1'b1, 1'b1, 1'b0, 1'b0, 8'h99);
    cmp_cnt++;
    if (sif.level !== 3'd4 || sif.snd_dout !== 8'hA1 || sif.overrun !== 1'b1) begin
      err_cnt++;
      $display("FAIL full_wr_ack: got level=%0d dout=%h overrun=%b required 4/a1/1",
               sif.level, sif.snd_dout, sif.overrun);
    end
    for (int i = 0; i < 3; i++) pulse(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    cmp_cnt++;
    if (sif.snd_dout !== 8'h99 || sif.level !== 3'd1) begin
      err_cnt++;
      $display("FAIL tail_99: got dout=%h level=%0d required 99/1", sif.snd_dout, sif.level);
    end
    pulse(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
  endtask
`endif

  task automatic test_back_to_back();
    bit wr, ack, rd, stat;
    for (int n = 0; n < 60; n++) begin
      wr   = 1'($urandom_range(0, 1));
      ack  = ($urandom_range(0, 2) == 0);
      rd   = ($urandom_range(0, 3) == 0);
      stat = ($urandom_range(0, 4) == 0);
      pulse(wr, ack, rd, stat, 8'($urandom));
      cmp_cnt++;
      if (obs() !== expv()) begin
        err_cnt++;
        $display("FAIL b2b_step_%0d: got %h required %h", n, obs(), expv());
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [14:0] rst_v;
    rst_v = {8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0};
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 8'hC3);
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 8'hC4);
    pulse(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    cmp_cnt++;
    if (obs() !== rst_v) begin
      err_cnt++;
      $display("FAIL async_reset: got %h required %h", obs(), rst_v);
    end
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 8'h77);
    cmp_cnt++;
    if (obs() !== expv() || sif.snd_dout !== 8'h77) begin
      err_cnt++;
      $display("FAIL after_reset_write: got %h required %h", obs(), expv());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_overwrite();
    test_wr_ack_same();
`ifdef SOUND_LATCH_FIFO_EN
    test_fifo_fill();
    test_fifo_full_wr_ack();
`endif
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/sound_latch.md
# sound_latch

Sound command latch: the responder for the main CPU's `SND` I/O write strobe produced by the I/O decode. It captures command bytes written by the main CPU, raises an interrupt to the sound CPU, and presents the byte on the sound CPU's latch read port until the sound CPU acknowledges it. A status bit (`pending`) is returned to the main CPU through the `FLAG` read path, and a sticky `overrun` bit is cleared by a main-CPU status read.

## Interface
- No parameters; depth is selected by `SOUND_LATCH_FIFO_EN`.
- `clk  in  1`  system clock; all state changes on rising edge.
- `reset_n  in  1`  asynchronous, active-low reset.
- `snd_wr  in  1`  main-side write strobe (decoded `SND`); level, edge-detected.
- `main_din  in  8`  command byte, sampled in the `snd_wr` edge cycle.
- `stat_rd  in  1`  main-side status read strobe (decoded `FLAG`); edge clears `overrun`.
- `snd_rd  in  1`  sound-side latch read strobe; edge-detected, informational only (no state change except `rd_seen`).
- `snd_ack  in  1`  sound-side acknowledge write strobe; edge pops/clears current entry.
- `snd_dout  out  8`  current (head) command byte.
- `snd_irq_n  out  1`  active-low interrupt to sound CPU.
- `pending  out  1`  1 while any unacknowledged byte is held.
- `overrun  out  1`  sticky: a write was lost or overwrote unread data.
- `level  out  3`  held-entry count (0..1 without FIFO, 0..4 with).
- `rd_seen  out  1`  set on `snd_rd` edge while pending; cleared on `snd_ack` edge.

## Operation
- Edge detect: one registered copy per strobe; event = strobe high AND previous low. Previous-value registers reset to 1, so a strobe held high across reset release is ignored until it falls and rises again.
- Single-entry mode (macro off):
  - Write event loads `main_din` and sets `pending`.
  - If `pending` was already 1 and there is no ack event in the same cycle, the data is overwritten and `overrun` is set.
  - Ack event clears `pending`; `snd_dout` keeps its last value.
  - Write and ack in the same cycle: the ack retires the old byte and the new byte becomes pending. `overrun` is not set.
- FIFO mode (macro on):
  - 4-entry circular buffer: 2-bit read and write pointers plus a 3-bit count; pointers wrap 3→0.
  - Write when not full pushes the byte. Write when full drops the byte and sets `overrun`.
  - Ack when not empty pops. Ack when empty is ignored.
  - Write and ack in the same cycle when full: pop and push both occur, count stays 4, no `overrun`.
  - Write and ack in the same cycle when empty: push only.
- `snd_dout` = head entry when count>0; otherwise the last popped value (0 after reset).
- `pending` = (count≠0). `snd_irq_n` = ~pending.
- `overrun` is cleared by a `stat_rd` event. If a `stat_rd` event and a new overrun occur in the same cycle, set wins.

## Timing
- All outputs are registered. Event in cycle N → outputs updated at the edge ending N, visible in N+1.
- Write-to-IRQ latency: `snd_irq_n` falls 1 clk after the `snd_wr` edge cycle.
- Ack-to-IRQ release: `snd_irq_n` rises 1 clk after the ack edge cycle. In FIFO mode it stays low if entries remain.
- Minimum strobe low time between events: 1 clk. Minimum high time: 1 clk.
- Reset values: `snd_dout`=0x00, `snd_irq_n`=1, `pending`=0, `overrun`=0, `level`=0, `rd_seen`=0, pointers=0.
- Reset asserted mid-operation discards all entries immediately (asynchronously).

## Configuration
- `SOUND_LATCH_FIFO_EN` defined: 4-deep FIFO as above; `level` ranges 0..4.
- Not defined: single 8-bit latch with overwrite semantics; `level` = {2'b00, pending}; FIFO storage and pointers are not synthesized.

## Test plan
- Reset then release with `snd_wr` held high → no event: `pending`=0, `snd_irq_n`=1 until `snd_wr` toggles low→high.
- Write 0x5A → `snd_irq_n`=0 and `snd_dout`=0x5A one clk later. `snd_rd` edge → `rd_seen`=1. Ack → `snd_irq_n`=1 next clk, `rd_seen`=0.
- Single-entry mode: write 0x11, then write 0x22 without ack → `snd_dout`=0x22, `overrun`=1. `stat_rd` edge → `overrun`=0.
- Single-entry mode: write 0x33 and ack in the same cycle while 0x11 is pending → `snd_dout`=0x33, `pending`=1, `overrun`=0.
- FIFO mode: write 0x01..0x05 → `level`=4, `overrun`=1, 0x05 dropped. Four acks → `snd_dout` sequence 0x01,0x02,0x03,0x04, then `snd_irq_n`=1, `level`=0.
- FIFO mode: with the FIFO full, write 0x99 and ack in the same cycle → `level`=4, head=0x02, tail=0x99, `overrun` unchanged. Then assert `reset_n`=0 mid-sequence → all outputs return to reset values immediately.
